// File: rtl/serial_seq_pkg.sv
// -----------------------------------------------------------------------------
// serial_seq_pkg
// Shared definitions for the single-bit serial sequence interface: the
// transmitter FSM state type, the frame-length adjustment for the optional
// parity bit, and a counter-width helper. Sequence detectors import this too.
//
// Configuration macro: SERIAL_SEQ_TX_PARITY_EN
//   defined   -> each frame carries one trailing even-parity bit
//   undefined -> frames are data bits only
// -----------------------------------------------------------------------------
package serial_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_tx_state_t;

`ifdef SERIAL_SEQ_TX_PARITY_EN
  localparam int unsigned SEQ_FRAME_EXTRA = 32'd1;
`else
  localparam int unsigned SEQ_FRAME_EXTRA = 32'd0;
`endif

  // Bits needed to hold the values 0..max_val, never fewer than one.
  function automatic int unsigned f_cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 32'd1);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// -----------------------------------------------------------------------------
// seq_down_counter
// Loadable down counter with a registered zero flag. Load has priority over
// decrement; decrementing stops at zero so the flag stays asserted.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high (count 0, zero flag 1)
//   i_load      in   load i_load_val on the next edge
//   i_load_val  in   W-bit load value
//   i_dec       in   decrement by one on the next edge (ignored at zero)
//   o_zero      out  count is zero in the current cycle
// -----------------------------------------------------------------------------
module seq_down_counter #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;
  logic         r_zero;
  logic [W-1:0] w_next;

  // Next-count selection: load beats decrement, hold otherwise.
  always_comb begin
    w_next = r_count;
    if (i_load) begin
      w_next = i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      w_next = r_count - W'(1'b1);
    end else begin
      w_next = r_count;
    end
  end

  // Count register with the zero flag registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_zero  <= 1'b1;
    end else begin
      r_count <= w_next;
      r_zero  <= (w_next == '0);
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/serial_seq_tx.sv
// -----------------------------------------------------------------------------
// serial_seq_tx
// Serial pattern transmitter. Accepts a parallel word over valid/ready and
// shifts it out MSB first, one bit per clock, with a bit-valid strobe, then
// pulses done_o and holds the line at 0 for GAP_CYCLES idle cycles.
//
// Configuration macro: SERIAL_SEQ_TX_PARITY_EN
//   defined -> an even-parity bit (XOR of the data bits) follows the LSB,
//              lengthening each frame by one bit.
//
// Parameters:
//   WIDTH       data word width (>= 1)
//   GAP_CYCLES  forced idle cycles after each frame (0 allowed)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high; aborts any frame
//   data_i       in   word to transmit, sampled on handshake
//   valid_i      in   word offered
//   ready_o      out  block can accept a word (registered)
//   bit_o        out  serial data line, 0 when not transmitting
//   bit_valid_o  out  bit_o carries a frame bit
//   done_o       out  one-cycle pulse in the cycle after the last frame bit
// -----------------------------------------------------------------------------
module serial_seq_tx
  import serial_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             done_o
);

  localparam int unsigned FRAME_LEN = WIDTH + SEQ_FRAME_EXTRA;
  localparam int unsigned BIT_CNT_W = f_cnt_width(FRAME_LEN);
  localparam int unsigned GAP_CNT_W = f_cnt_width(GAP_CYCLES);

  // Counters are loaded with (length - 1) so the zero flag marks the final
  // cycle of the phase.
  localparam logic [BIT_CNT_W-1:0] BIT_LOAD = BIT_CNT_W'(FRAME_LEN - 32'd1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 32'd0) ? GAP_CNT_W'(GAP_CYCLES - 32'd1) : '0;

  seq_tx_state_t        r_state;
  logic [FRAME_LEN-1:0] r_shift;
  logic                 r_bit;
  logic                 r_bit_valid;
  logic                 r_done;
  logic                 r_ready;

  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_accept;
  logic                 w_bit_load;
  logic                 w_bit_dec;
  logic                 w_bit_zero;
  logic                 w_gap_load;
  logic                 w_gap_dec;
  logic                 w_gap_zero;

`ifdef SERIAL_SEQ_TX_PARITY_EN
  // Even parity: the XOR of all data bits, so the frame has an even count of 1s.
  function automatic logic f_even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  assign w_frame = {data_i, f_even_parity(data_i)};
`else
  assign w_frame = data_i;
`endif

  // r_ready is itself a register, so valid_i never reaches ready_o.
  assign w_accept   = (r_state == IDLE) && valid_i && r_ready;
  assign w_bit_load = w_accept;
  assign w_bit_dec  = (r_state == SHIFT) && !w_bit_zero;
  assign w_gap_load = (r_state == SHIFT) && w_bit_zero;
  assign w_gap_dec  = (r_state == GAP) && !w_gap_zero;

  seq_down_counter #(.W(BIT_CNT_W)) u_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_bit_load),
    .i_load_val (BIT_LOAD),
    .i_dec      (w_bit_dec),
    .o_zero     (w_bit_zero)
  );

  seq_down_counter #(.W(GAP_CNT_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

  // Transmitter FSM with all outputs registered.
  // The first frame bit is loaded straight into r_bit at acceptance; r_shift
  // then holds only the bits still to be sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit       <= 1'b0;
      r_bit_valid <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift     <= w_frame << 1;
            r_bit       <= w_frame[FRAME_LEN-1];
            r_bit_valid <= 1'b1;
            r_ready     <= 1'b0;
            r_state     <= SHIFT;
          end else begin
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_ready     <= 1'b1;
            r_state     <= IDLE;
          end
        end
        SHIFT: begin
          if (w_bit_zero) begin
            // Last bit is on the line this cycle; close the frame.
            r_shift     <= '0;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b1;
            if (GAP_CYCLES == 32'd0) begin
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_ready <= 1'b0;
              r_state <= GAP;
            end
          end else begin
            r_shift     <= r_shift << 1;
            r_bit       <= r_shift[FRAME_LEN-1];
            r_bit_valid <= 1'b1;
            r_ready     <= 1'b0;
            r_state     <= SHIFT;
          end
        end
        GAP: begin
          r_bit       <= 1'b0;
          r_bit_valid <= 1'b0;
          if (w_gap_zero) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_ready <= 1'b0;
            r_state <= GAP;
          end
        end
        default: begin
          r_shift     <= '0;
          r_bit       <= 1'b0;
          r_bit_valid <= 1'b0;
          r_ready     <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign bit_o       = r_bit;
  assign bit_valid_o = r_bit_valid;
  assign done_o      = r_done;

endmodule

// File: tb/tb_serial_seq_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_seq_tx
// Directed self-checking bench for serial_seq_tx. Two instances: u_dut_g1
// (WIDTH=4, GAP_CYCLES=1) and u_dut_g0 (WIDTH=4, GAP_CYCLES=0). A small
// behavioural 1001 detector watches the GAP_CYCLES=1 instance.
// Honours SERIAL_SEQ_TX_PARITY_EN for frame length and expected frames.
// -----------------------------------------------------------------------------
module tb_serial_seq_tx;

`ifdef SERIAL_SEQ_TX_PARITY_EN
  localparam int FL = 5;
  localparam logic [FL-1:0] EXP_1001 = 5'b10010;
  localparam logic [FL-1:0] EXP_0110 = 5'b01100;
  localparam logic [FL-1:0] EXP_1111 = 5'b11110;
`else
  localparam int FL = 4;
  localparam logic [FL-1:0] EXP_1001 = 4'b1001;
  localparam logic [FL-1:0] EXP_0110 = 4'b0110;
  localparam logic [FL-1:0] EXP_1111 = 4'b1111;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, bit_a, bv_a, done_a;
  logic       ready_b, bit_b, bv_b, done_b;

  int checks = 0;
  int errors = 0;

  logic [2:0] det_hist;
  int         det_hits = 0;

  always #5 clk = ~clk;

  serial_seq_tx #(.WIDTH(4), .GAP_CYCLES(1)) u_dut_g1 (
    .clk(clk), .rst(rst), .data_i(data_a), .valid_i(valid_a),
    .ready_o(ready_a), .bit_o(bit_a), .bit_valid_o(bv_a), .done_o(done_a)
  );

  serial_seq_tx #(.WIDTH(4), .GAP_CYCLES(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .data_i(data_b), .valid_i(valid_b),
    .ready_o(ready_b), .bit_o(bit_b), .bit_valid_o(bv_b), .done_o(done_b)
  );

  // Behavioural 1001 detector fed from the valid serial bits.
  always @(posedge clk) begin
    if (rst) begin
      det_hist <= 3'b000;
    end else if (bv_a) begin
      det_hist <= {det_hist[1:0], bit_a};
      if ({det_hist, bit_a} == 4'b1001) det_hits <= det_hits + 1;
    end
  end

  task automatic test_reset();
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = 4'h0; data_b = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b/%b expected 0/0", ready_a, ready_b); end
    checks++; if (bit_a !== 1'b0 || bv_a !== 1'b0 || done_a !== 1'b0) begin errors++;
      $display("FAIL reset_outputs: got bit=%b valid=%b done=%b expected 0 0 0", bit_a, bv_a, done_a); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1) begin errors++;
      $display("FAIL reset_release_ready: got %b/%b expected 1/1", ready_a, ready_b); end
  endtask

  task automatic test_single_frame(input string name, input logic [3:0] data, input logic [FL-1:0] exp);
    @(negedge clk);
    checks++; if (ready_a !== 1'b1) begin errors++;
      $display("FAIL %s_ready_before: got %b expected 1", name, ready_a); end
    data_a = data; valid_a = 1'b1;
    @(posedge clk); #1 valid_a = 1'b0; data_a = ~data;
    for (int p = 0; p < FL; p++) begin
      @(negedge clk);
      checks++;
      if (bit_a !== exp[FL-1-p] || bv_a !== 1'b1 || done_a !== 1'b0 || ready_a !== 1'b0) begin errors++;
        $display("FAIL %s_bit%0d: got bit=%b valid=%b done=%b ready=%b expected bit=%b valid=1 done=0 ready=0",
                 name, p, bit_a, bv_a, done_a, ready_a, exp[FL-1-p]); end
    end
    @(negedge clk);
    checks++; if (done_a !== 1'b1 || bv_a !== 1'b0 || bit_a !== 1'b0 || ready_a !== 1'b0) begin errors++;
      $display("FAIL %s_done: got done=%b valid=%b bit=%b ready=%b expected 1 0 0 0", name, done_a, bv_a, bit_a, ready_a); end
    @(negedge clk);
    checks++; if (done_a !== 1'b0 || ready_a !== 1'b1 || bv_a !== 1'b0) begin errors++;
      $display("FAIL %s_ready_after: got done=%b ready=%b valid=%b expected 0 1 0", name, done_a, ready_a, bv_a); end
  endtask

  task automatic test_detector();
    checks++; if (det_hits !== 1) begin errors++;
      $display("FAIL detector_1001: got %0d hits expected 1", det_hits); end
  endtask

  task automatic test_back_to_back();
    logic [FL-1:0] frame;
    int p;
    logic eb, ev, ed, er;
    frame = EXP_0110;
    @(negedge clk);
    data_a = 4'b0110; valid_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3 * (FL + 2); k++) begin
      @(negedge clk);
      p  = k % (FL + 2);
      eb = (p < FL) ? frame[FL-1-p] : 1'b0;
      ev = (p < FL);
      ed = (p == FL);
      er = (p == FL + 1);
      checks++;
      if (bit_a !== eb || bv_a !== ev || done_a !== ed || ready_a !== er) begin errors++;
        $display("FAIL b2b_cycle%0d: got bit=%b valid=%b done=%b ready=%b expected %b %b %b %b",
                 k, bit_a, bv_a, done_a, ready_a, eb, ev, ed, er); end
    end
    valid_a = 1'b0;
    @(negedge clk);
    checks++; if (bv_a !== 1'b0 || ready_a !== 1'b1) begin errors++;
      $display("FAIL b2b_stop: got valid=%b ready=%b expected 0 1", bv_a, ready_a); end
  endtask

  task automatic test_gap0();
    logic [FL-1:0] frame;
    frame = EXP_1111;
    @(negedge clk);
    checks++; if (ready_b !== 1'b1) begin errors++;
      $display("FAIL gap0_ready_before: got %b expected 1", ready_b); end
    data_b = 4'b1111; valid_b = 1'b1;
    @(posedge clk);
    for (int p = 0; p < FL; p++) begin
      @(negedge clk);
      checks++;
      if (bit_b !== frame[FL-1-p] || bv_b !== 1'b1 || done_b !== 1'b0 || ready_b !== 1'b0) begin errors++;
        $display("FAIL gap0_bit%0d: got bit=%b valid=%b done=%b ready=%b expected bit=%b valid=1 done=0 ready=0",
                 p, bit_b, bv_b, done_b, ready_b, frame[FL-1-p]); end
    end
    @(negedge clk);
    checks++; if (done_b !== 1'b1 || ready_b !== 1'b1 || bv_b !== 1'b0 || bit_b !== 1'b0) begin errors++;
      $display("FAIL gap0_done_ready: got done=%b ready=%b valid=%b bit=%b expected 1 1 0 0", done_b, ready_b, bv_b, bit_b); end
    @(negedge clk);
    checks++; if (bv_b !== 1'b1 || bit_b !== 1'b1 || done_b !== 1'b0 || ready_b !== 1'b0) begin errors++;
      $display("FAIL gap0_next_frame: got valid=%b bit=%b done=%b ready=%b expected 1 1 0 0", bv_b, bit_b, done_b, ready_b); end
    valid_b = 1'b0;
    repeat (FL + 1) @(negedge clk);
    checks++; if (ready_b !== 1'b1 || done_b !== 1'b0 || bv_b !== 1'b0) begin errors++;
      $display("FAIL gap0_settle: got ready=%b done=%b valid=%b expected 1 0 0", ready_b, done_b, bv_b); end
  endtask

  task automatic test_ignore_valid();
    logic [FL-1:0] frame;
    frame = EXP_1001;
    @(negedge clk);
    data_a = 4'b1001; valid_a = 1'b1;
    @(posedge clk); #1 valid_a = 1'b0;
    for (int p = 0; p < FL; p++) begin
      @(negedge clk);
      checks++;
      if (bit_a !== frame[FL-1-p] || bv_a !== 1'b1) begin errors++;
        $display("FAIL ignore_bit%0d: got bit=%b valid=%b expected bit=%b valid=1", p, bit_a, bv_a, frame[FL-1-p]); end
      if (p == 1) begin data_a = 4'b0110; valid_a = 1'b1; end
      if (p == 2) valid_a = 1'b0;
    end
    @(negedge clk);
    checks++; if (done_a !== 1'b1) begin errors++;
      $display("FAIL ignore_done: got %b expected 1", done_a); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bv_a !== 1'b0 || ready_a !== 1'b1) begin errors++;
      $display("FAIL ignore_no_extra_frame: got valid=%b ready=%b expected 0 1", bv_a, ready_a); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    data_a = 4'b1001; valid_a = 1'b1;
    @(posedge clk); #1 valid_a = 1'b0;
    @(negedge clk);
    checks++; if (bit_a !== 1'b1 || bv_a !== 1'b1) begin errors++;
      $display("FAIL rstmid_first_bit: got bit=%b valid=%b expected 1 1", bit_a, bv_a); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bit_a !== 1'b0 || bv_a !== 1'b0 || done_a !== 1'b0 || ready_a !== 1'b0) begin errors++;
      $display("FAIL rstmid_abort: got bit=%b valid=%b done=%b ready=%b expected 0 0 0 0", bit_a, bv_a, done_a, ready_a); end
    @(negedge clk);
    checks++; if (ready_a !== 1'b1) begin errors++;
      $display("FAIL rstmid_ready: got %b expected 1", ready_a); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (done_a !== 1'b0 || bv_a !== 1'b0) begin errors++;
        $display("FAIL rstmid_quiet%0d: got done=%b valid=%b expected 0 0", k, done_a, bv_a); end
    end
  endtask

  task automatic test_reset_vs_handshake();
    @(negedge clk);
    data_a = 4'b1111; valid_a = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; valid_a = 1'b0;
    @(negedge clk);
    checks++; if (bv_a !== 1'b0 || ready_a !== 1'b0) begin errors++;
      $display("FAIL rst_wins_cycle1: got valid=%b ready=%b expected 0 0", bv_a, ready_a); end
    @(negedge clk);
    checks++; if (bv_a !== 1'b0 || ready_a !== 1'b1) begin errors++;
      $display("FAIL rst_wins_cycle2: got valid=%b ready=%b expected 0 1", bv_a, ready_a); end
  endtask

  initial begin
    test_reset();
    test_single_frame("basic_1001", 4'b1001, EXP_1001);
    test_detector();
    test_back_to_back();
    test_gap0();
    test_ignore_valid();
`ifdef SERIAL_SEQ_TX_PARITY_EN
    test_single_frame("parity_1011", 4'b1011, 5'b10111);
`else
    test_single_frame("frame_1011", 4'b1011, 4'b1011);
`endif
    test_reset_mid();
    test_reset_vs_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
